// File: rtl/rr_fifo_arbiter_param.sv
// N_CH write channels, each buffered in its own DEPTH-entry FIFO, merged onto
// one registered output stream in round-robin order (strict or work-conserving).
module rr_fifo_arbiter_param #(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter int SKIP_EMPTY = 0,
  localparam int CH_W      = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          wen,
  input  logic [N_CH*DATA_W-1:0]   din,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        dout,
  output logic                     valid,
  output logic [CH_W-1:0]          chan,
  output logic [N_CH-1:0]          full,
  output logic [N_CH-1:0]          drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = CH_W + 1;

  logic [N_CH-1:0]   w_nonempty;
  logic [N_CH-1:0]   w_pop;
  logic [DATA_W-1:0] w_head [N_CH];
  logic [CH_W-1:0]   w_cand [N_CH];
  logic              w_found;
  logic [CH_W-1:0]   w_gsel;

  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic [CH_W-1:0]   r_chan;
  logic [CH_W-1:0]   r_ptr;

  function automatic logic [CH_W-1:0] f_next(input logic [CH_W-1:0] p);
    return (p == CH_W'(N_CH - 1)) ? '0 : p + CH_W'(1);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] r_mem [DEPTH];
      logic [AW-1:0]     r_wptr;
      logic [AW-1:0]     r_rptr;
      logic [CW-1:0]     r_count;
      logic              r_drop;
      logic              w_push;
      logic [PW-1:0]     w_sum;

      // Full is judged on pre-edge occupancy, so a same-cycle pop frees no room.
      assign full[gi]       = (r_count == CW'(DEPTH));
      assign w_push         = wen[gi] && !full[gi];
      assign w_nonempty[gi] = (r_count != '0);
      assign w_head[gi]     = r_mem[r_rptr];
      assign w_pop[gi]      = out_ready && w_found && (w_gsel == CH_W'(gi));
      assign drop_err[gi]   = r_drop;

      // Candidate at search offset gi from the pointer, modulo N_CH.
      assign w_sum       = {1'b0, r_ptr} + PW'(gi);
      assign w_cand[gi]  = (w_sum >= PW'(N_CH)) ? CH_W'(w_sum - PW'(N_CH)) : CH_W'(w_sum);

      always_ff @(posedge clk) begin
        if (w_push && !rst) begin
          r_mem[r_wptr] <= din[gi*DATA_W +: DATA_W];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_count <= '0;
          r_drop  <= 1'b0;
        end else begin
          if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
          end
          if (w_pop[gi]) begin
            r_rptr <= r_rptr + AW'(1);
          end
          case ({w_push, w_pop[gi]})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
          endcase
          if (wen[gi] && full[gi]) begin
            r_drop <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // Lowest search offset wins, so scan from the far end and let nearer hits overwrite.
  always_comb begin
    w_found = 1'b0;
    w_gsel  = r_ptr;
    if (SKIP_EMPTY == 0) begin
      w_found = w_nonempty[r_ptr];
    end else begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        if (w_nonempty[w_cand[k]]) begin
          w_found = 1'b1;
          w_gsel  = w_cand[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else if (out_ready) begin
      if (w_found) begin
        r_dout  <= w_head[w_gsel];
        r_valid <= 1'b1;
        r_chan  <= w_gsel;
        r_ptr   <= f_next(w_gsel);
      end else begin
        r_dout  <= '0;
        r_valid <= 1'b0;
        if (SKIP_EMPTY == 0) begin
          r_chan <= r_ptr;
          r_ptr  <= f_next(r_ptr);
        end
      end
    end
  end

  assign dout  = r_dout;
  assign valid = r_valid;
  assign chan  = r_chan;

endmodule
